// File: rtl/seq_digit_comparator.sv
// seq_digit_comparator: digit-serial unsigned magnitude comparator.
// Snapshots two packed multi-digit words and scans them MSB digit first,
// one digit per cycle, stopping at the first digit that differs. Registers
// L/E/R flags, a DONE pulse, a rising-match pulse and a latched alarm.
module seq_digit_comparator #(
  parameter int DIGITS = 6,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 EN,
  input  logic                 START,
  input  logic [DIGITS*DW-1:0] A,
  input  logic [DIGITS*DW-1:0] B,
  input  logic                 ARM,
  input  logic                 ACK,
  output logic                 L,
  output logic                 E,
  output logic                 R,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 MATCH_RISE,
  output logic                 ALARM
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DIGITS*DW-1:0] a_snap_q, a_snap_d;
  logic [DIGITS*DW-1:0] b_snap_q, b_snap_d;
  logic                 l_q, l_d;
  logic                 e_q, e_d;
  logic                 r_q, r_d;
  logic                 done_q, done_d;
  logic                 match_rise_q, match_rise_d;
  logic                 prev_e_q, prev_e_d;
  logic                 alarm_q, alarm_d;

  logic [DW-1:0]        a_dig;
  logic [DW-1:0]        b_dig;

  // Select the snapshot digit currently under inspection.
  always_comb begin
    a_dig = a_snap_q[int'(idx_q)*DW +: DW];
    b_dig = b_snap_q[int'(idx_q)*DW +: DW];
  end

  // Next-state logic: scan control, result flags, match edge and alarm latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    a_snap_d     = a_snap_q;
    b_snap_d     = b_snap_q;
    l_d          = l_q;
    e_d          = e_q;
    r_d          = r_q;
    done_d       = 1'b0;
    match_rise_d = 1'b0;
    prev_e_d     = prev_e_q;
    alarm_d      = alarm_q;

    if (!EN) begin
      // Disabling throws away any scan in flight and forgets the last result,
      // so the next equal compare counts as a fresh match.
      state_d  = ST_IDLE;
      l_d      = 1'b0;
      e_d      = 1'b0;
      r_d      = 1'b0;
      prev_e_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            a_snap_d = A;
            b_snap_d = B;
            idx_d    = IW'(DIGITS - 1);
            state_d  = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (a_dig != b_dig) begin
            l_d     = (a_dig > b_dig);
            e_d     = 1'b0;
            r_d     = (a_dig < b_dig);
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (idx_q == '0) begin
            l_d     = 1'b0;
            e_d     = 1'b1;
            r_d     = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (done_d) begin
        match_rise_d = e_d & ~prev_e_q;
        prev_e_d     = e_d;
      end
    end

    // Disarming always wins; a new match beats a simultaneous acknowledge so
    // that an alarm is never silently swallowed.
    if (!ARM) begin
      alarm_d = 1'b0;
    end else if (match_rise_d) begin
      alarm_d = 1'b1;
    end else if (ACK) begin
      alarm_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      a_snap_q     <= '0;
      b_snap_q     <= '0;
      l_q          <= 1'b0;
      e_q          <= 1'b0;
      r_q          <= 1'b0;
      done_q       <= 1'b0;
      match_rise_q <= 1'b0;
      prev_e_q     <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      a_snap_q     <= a_snap_d;
      b_snap_q     <= b_snap_d;
      l_q          <= l_d;
      e_q          <= e_d;
      r_q          <= r_d;
      done_q       <= done_d;
      match_rise_q <= match_rise_d;
      prev_e_q     <= prev_e_d;
      alarm_q      <= alarm_d;
    end
  end

  assign L          = l_q;
  assign E          = e_q;
  assign R          = r_q;
  assign BUSY       = (state_q == ST_SCAN);
  assign DONE       = done_q;
  assign MATCH_RISE = match_rise_q;
  assign ALARM      = alarm_q;

endmodule

// File: tb/tb_seq_digit_comparator.sv
// tb_seq_digit_comparator: directed self-checking bench for the digit-serial
// comparator (DIGITS=6, DW=4) using immediate assertions.
module tb_seq_digit_comparator;

  logic        clk;
  logic        rst_n;
  logic        EN;
  logic        START;
  logic [23:0] A;
  logic [23:0] B;
  logic        ARM;
  logic        ACK;
  logic        L, E, R, BUSY, DONE, MATCH_RISE, ALARM;

  int compared;
  int mismatched;

  seq_digit_comparator #(.DIGITS(6), .DW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .EN        (EN),
    .START     (START),
    .A         (A),
    .B         (B),
    .ARM       (ARM),
    .ACK       (ACK),
    .L         (L),
    .E         (E),
    .R         (R),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .MATCH_RISE(MATCH_RISE),
    .ALARM     (ALARM)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Request a compare; returns just after the edge that accepted START.
  task automatic start_compare(input logic [23:0] a_val, input logic [23:0] b_val);
    A     = a_val;
    B     = b_val;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Count edges until DONE is seen, bounded so a stuck DUT cannot hang.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (DONE !== 1'b1 && n < 20);
  endtask

  int cyc;
  int done_cnt;
  logic [2:0] flags_at_done;

  initial begin
    rst_n = 1'b0;
    EN    = 1'b0;
    START = 1'b0;
    A     = '0;
    B     = '0;
    ARM   = 1'b0;
    ACK   = 1'b0;
    compared   = 0;
    mismatched = 0;

    // 1: reset with toggling operands, then idle without START.
    for (int i = 0; i < 4; i++) begin
      A = 24'h111111 * (i + 1);
      B = 24'hABCDEF ^ A;
      START = 1'b1;
      EN    = 1'b1;
      tick();
    end
    check_output("reset_outputs", {25'd0, L, E, R, BUSY, DONE, MATCH_RISE, ALARM}, 32'd0);
    START = 1'b0;
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (DONE === 1'b1 || BUSY === 1'b1) done_cnt++;
    end
    check_output("idle_no_done", done_cnt, 0);

    // 2: full match, then the same match again.
    start_compare(24'h123456, 24'h123456);
    check_output("busy_after_start", {31'd0, BUSY}, 32'd1);
    wait_done(cyc);
    check_output("eq_latency", cyc, 6);
    check_output("eq_flags", {29'd0, L, E, R}, 32'b010);
    check_output("eq_match_rise", {31'd0, MATCH_RISE}, 32'd1);
    check_output("eq_alarm_unarmed", {31'd0, ALARM}, 32'd0);
    tick();
    check_output("done_is_pulse", {30'd0, DONE, BUSY}, 32'd0);
    check_output("flags_hold", {29'd0, L, E, R}, 32'b010);
    start_compare(24'h123456, 24'h123456);
    wait_done(cyc);
    check_output("eq2_latency", cyc, 6);
    check_output("eq2_flags", {29'd0, L, E, R}, 32'b010);
    check_output("eq2_no_rise", {31'd0, MATCH_RISE}, 32'd0);

    // 3: MSB difference (A>B) and LSB difference (A<B).
    start_compare(24'h923456, 24'h123456);
    wait_done(cyc);
    check_output("gt_latency", cyc, 1);
    check_output("gt_flags", {29'd0, L, E, R}, 32'b100);
    start_compare(24'h123455, 24'h123456);
    wait_done(cyc);
    check_output("lt_latency", cyc, 6);
    check_output("lt_flags", {29'd0, L, E, R}, 32'b001);
    start_compare(24'h12F456, 24'h123456);
    wait_done(cyc);
    check_output("nonbcd_latency", cyc, 3);
    check_output("nonbcd_flags", {29'd0, L, E, R}, 32'b100);

    // 4: operand change and second START mid-scan are ignored.
    start_compare(24'h123456, 24'h123456);
    A     = 24'h999999;
    START = 1'b1;
    tick();
    START = 1'b0;
    done_cnt = 0;
    flags_at_done = 3'b000;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (DONE === 1'b1) begin
        done_cnt++;
        flags_at_done = {L, E, R};
      end
    end
    check_output("snapshot_one_done", done_cnt, 1);
    check_output("snapshot_flags", {29'd0, flags_at_done}, 32'b010);

    // 5: EN dropped in the third SCAN cycle aborts the scan.
    start_compare(24'h123456, 24'h123456);
    tick();
    tick();
    EN = 1'b0;
    tick();
    check_output("abort_state", {26'd0, L, E, R, BUSY, DONE, MATCH_RISE}, 32'd0);
    EN = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (DONE === 1'b1) done_cnt++;
    end
    check_output("abort_no_done", done_cnt, 0);
    start_compare(24'h123456, 24'h123456);
    wait_done(cyc);
    check_output("rerun_flags", {29'd0, L, E, R}, 32'b010);
    check_output("rerun_rise", {31'd0, MATCH_RISE}, 32'd1);

    // 6: alarm set, acknowledge, set-beats-ack, disarm.
    ARM = 1'b1;
    start_compare(24'h923456, 24'h123456);
    wait_done(cyc);
    start_compare(24'h123456, 24'h123456);
    wait_done(cyc);
    check_output("alarm_set", {30'd0, MATCH_RISE, ALARM}, 32'b11);
    tick();
    check_output("alarm_latched", {31'd0, ALARM}, 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    check_output("alarm_ack", {31'd0, ALARM}, 32'd0);
    start_compare(24'h000001, 24'h123456);
    wait_done(cyc);
    ACK = 1'b1;
    start_compare(24'h123456, 24'h123456);
    wait_done(cyc);
    check_output("alarm_set_beats_ack", {30'd0, MATCH_RISE, ALARM}, 32'b11);
    ACK = 1'b0;
    ARM = 1'b0;
    tick();
    check_output("alarm_disarm", {31'd0, ALARM}, 32'd0);

    // Reset asserted mid-scan returns everything to reset values at once.
    start_compare(24'h123456, 24'h123456);
    tick();
    rst_n = 1'b0;
    #1;
    check_output("reset_mid_scan", {25'd0, L, E, R, BUSY, DONE, MATCH_RISE, ALARM}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
